// File: rtl/axi4_lite_slave_mem_responder_pkg.sv
// axi4_lite_slave_mem_responder_pkg: shared AXI4-Lite encodings, delay default and FSM state types
package axi4_lite_slave_mem_responder_pkg;

    localparam int DEFAULT_DELAY_WIDTH = 4;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } brespEnum;

    typedef enum logic [1:0] {
        RRESP_OKAY   = 2'b00,
        RRESP_EXOKAY = 2'b01,
        RRESP_SLVERR = 2'b10,
        RRESP_DECERR = 2'b11
    } rrespEnum;

    typedef enum logic [1:0] {IDLE, DELAY, READY} delayStateEnum;

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_ADDR, R_RESP} readStateEnum;

endpackage

// File: rtl/axi4_lite_slave_mem_responder_ready_delay_counter.sv
// axi4_lite_ready_delay_counter: registered ready generator that waits cfg_delay_i edges after valid_i
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   valid_i         channel valid
//   hold_i          blocks a new start while the channel is still holding a transfer
//   cfg_delay_i     delay, sampled on the starting edge only
//   ready_o         one-cycle registered ready
//   ready_next_o    ready_o of the next cycle, for FSMs that track this counter
module axi4_lite_ready_delay_counter
    import axi4_lite_slave_mem_responder_pkg::*;
#(
    parameter int DELAY_WIDTH = DEFAULT_DELAY_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic                   hold_i,
    input  logic [DELAY_WIDTH-1:0] cfg_delay_i,
    output logic                   ready_o,
    output logic                   ready_next_o
);

    delayStateEnum          state_q, state_d;
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (valid_i && !hold_i) begin
                cnt_d   = cfg_delay_i;
                state_d = (cfg_delay_i == '0) ? READY : DELAY;
            end
            DELAY: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == DELAY_WIDTH'(1)) ? READY : DELAY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end

    assign ready_o      = state_q == READY;
    assign ready_next_o = state_d == READY;

endmodule

// File: rtl/axi4_lite_slave_mem_responder.sv
// axi4_lite_slave_mem_responder: AXI4-Lite slave backed by a word memory with per-channel ready delays
//   aclk, aresetn                   clock, asynchronous active-low reset
//   aw*/w*/b*                       write address, data and response channels
//   ar*/r*                          read address and data channels
//   cfg_write_delay/cfg_read_delay  ready delay for AW+W and for AR
module axi4_lite_slave_mem_responder
    import axi4_lite_slave_mem_responder_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       MEM_DEPTH     = 256,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                       DELAY_WIDTH   = DEFAULT_DELAY_WIDTH,
    localparam int                      STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ADDRESS_WIDTH-1:0] awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [STRB_WIDTH-1:0]    wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDRESS_WIDTH-1:0] araddr,
    input  logic [2:0]               arprot,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic [DELAY_WIDTH-1:0]   cfg_write_delay,
    input  logic [DELAY_WIDTH-1:0]   cfg_read_delay
);

    localparam int OFF_BITS = $clog2(STRB_WIDTH);
    localparam int IDX_BITS = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];
    logic                     aw_hs, w_hs, ar_hs, b_hs, commit;
    logic                     aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q, wr_addr, wr_off, rd_off;
    logic [2:0]               aw_prot_q, ar_prot_q;
    logic [DATA_WIDTH-1:0]    w_data_q, wr_data, rdata_q;
    logic [STRB_WIDTH-1:0]    w_strb_q, wr_strb;
    logic                     wr_ok, rd_ok;
    logic [IDX_BITS-1:0]      wr_idx, rd_idx;
    logic                     bvalid_q;
    brespEnum                 bresp_q;
    rrespEnum                 rresp_q;
    readStateEnum             r_state_q, r_state_d;
    logic                     aw_nxt, w_nxt, ar_nxt;
    logic                     unused_bits;

    axi4_lite_ready_delay_counter #(.DELAY_WIDTH(DELAY_WIDTH)) u_aw_delay (
        .clk_i(aclk), .rst_ni(aresetn), .valid_i(awvalid), .hold_i(aw_held_q),
        .cfg_delay_i(cfg_write_delay), .ready_o(awready), .ready_next_o(aw_nxt)
    );

    axi4_lite_ready_delay_counter #(.DELAY_WIDTH(DELAY_WIDTH)) u_w_delay (
        .clk_i(aclk), .rst_ni(aresetn), .valid_i(wvalid), .hold_i(w_held_q),
        .cfg_delay_i(cfg_write_delay), .ready_o(wready), .ready_next_o(w_nxt)
    );

    axi4_lite_ready_delay_counter #(.DELAY_WIDTH(DELAY_WIDTH)) u_ar_delay (
        .clk_i(aclk), .rst_ni(aresetn), .valid_i(arvalid), .hold_i(r_state_q == R_RESP),
        .cfg_delay_i(cfg_read_delay), .ready_o(arready), .ready_next_o(ar_nxt)
    );

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;
    assign b_hs  = bvalid_q && bready;

    // A channel handshaking on this edge counts as held, so a write whose
    // last half arrives now commits on the same edge straight from the bus.
    assign wr_addr   = aw_held_q ? aw_addr_q : awaddr;
    assign wr_data   = w_held_q ? w_data_q : wdata;
    assign wr_strb   = w_held_q ? w_strb_q : wstrb;
    assign commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
    assign aw_held_d = !commit && (aw_held_q || aw_hs);
    assign w_held_d  = !commit && (w_held_q || w_hs);

    // Out of range below BASE_ADDR wraps the offset high, so the index test also rejects it.
    assign wr_off = wr_addr - BASE_ADDR;
    assign wr_ok  = (wr_addr >= BASE_ADDR) && ((wr_off >> OFF_BITS) < ADDRESS_WIDTH'(MEM_DEPTH));
    assign wr_idx = wr_off[OFF_BITS +: IDX_BITS];
    assign rd_off = araddr - BASE_ADDR;
    assign rd_ok  = (araddr >= BASE_ADDR) && ((rd_off >> OFF_BITS) < ADDRESS_WIDTH'(MEM_DEPTH));
    assign rd_idx = rd_off[OFF_BITS +: IDX_BITS];

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  r_state_d = ar_nxt ? R_ADDR : (arvalid ? R_DELAY : R_IDLE);
            R_DELAY: r_state_d = ar_nxt ? R_ADDR : R_DELAY;
            R_ADDR:  r_state_d = arvalid ? R_RESP : R_IDLE;
            R_RESP:  r_state_d = rready ? R_IDLE : R_RESP;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= BRESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RRESP_OKAY;
            ar_prot_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            if (aw_hs) begin
                aw_addr_q <= awaddr;
                aw_prot_q <= awprot;
            end
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? BRESP_OKAY : BRESP_DECERR;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
            end
            // Nonblocking read of mem returns pre-write data on a same-edge commit.
            if (ar_hs) begin
                rdata_q   <= rd_ok ? mem[rd_idx] : '0;
                rresp_q   <= rd_ok ? RRESP_OKAY : RRESP_DECERR;
                ar_prot_q <= arprot;
            end
        end

    always_ff @(posedge aclk)
        if (commit && wr_ok)
            for (int b = 0; b < STRB_WIDTH; b++)
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];

    assign bvalid      = bvalid_q;
    assign bresp       = bresp_q;
    assign rvalid      = r_state_q == R_RESP;
    assign rdata       = rdata_q;
    assign rresp       = rresp_q;
    assign unused_bits = ^{aw_prot_q, ar_prot_q, aw_nxt, w_nxt};

endmodule

// File: tb/tb_axi4_lite_slave_mem_responder.sv
// tb_axi4_lite_slave_mem_responder: directed self-checking bench for the AXI4-Lite memory slave
module tb_axi4_lite_slave_mem_responder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [3:0]  cfg_write_delay = '0, cfg_read_delay = '0;
    int          pass_cnt = 0, total_cnt = 0;

    always #5 aclk = ~aclk;

    axi4_lite_slave_mem_responder dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .cfg_write_delay(cfg_write_delay), .cfg_read_delay(cfg_read_delay)
    );

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
        int   n;
        logic aw_f, w_f;
        n = 0;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
        while ((awvalid || wvalid) && n < 40) begin
            aw_f = awready; w_f = wready;
            tick();
            if (aw_f) awvalid = 0;
            if (w_f) wvalid = 0;
            n++;
        end
        while (!bvalid && n < 40) begin
            tick();
            n++;
        end
        total_cnt++;
        if (bvalid !== 1'b1) $display("FAIL write_timeout addr=%h bvalid=%b expected=1", addr, bvalid);
        else pass_cnt++;
        resp = bresp;
        awvalid = 0; wvalid = 0; bready = 1;
        tick();
        bready = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat);
        int n;
        n = 0;
        araddr = addr; arvalid = 1;
        tick();
        while (!arready && n < 40) begin
            tick();
            n++;
        end
        lat = n;
        tick();
        arvalid = 0;
        total_cnt++;
        if (rvalid !== 1'b1) $display("FAIL read_timeout addr=%h rvalid=%b expected=1", addr, rvalid);
        else pass_cnt++;
        data = rdata; resp = rresp; rready = 1;
        tick();
        rready = 0;
    endtask

    task automatic test_reset();
        #2 aresetn = 0;
        repeat (3) tick();
        total_cnt++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
            $display("FAIL reset_during got=%b expected=00000", {awready, wready, arready, bvalid, rvalid});
        else pass_cnt++;
        aresetn = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++;
            if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
                $display("FAIL idle_cycle%0d got=%b expected=00000", i, {awready, wready, arready, bvalid, rvalid});
            else pass_cnt++;
        end
        total_cnt++;
        if ({bresp, rresp, rdata} !== 36'h0)
            $display("FAIL reset_resp_data got=%h expected=0", {bresp, rresp, rdata});
        else pass_cnt++;
    endtask

    task automatic test_write_delay();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        cfg_write_delay = 3;
        awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if ({awready, wready} !== 2'b00) $display("FAIL wdelay_early%0d got=%b expected=00", i, {awready, wready});
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({awready, wready, bvalid} !== 3'b110) $display("FAIL wdelay_ready got=%b expected=110", {awready, wready, bvalid});
        else pass_cnt++;
        tick();
        awvalid = 0; wvalid = 0;
        total_cnt++;
        if ({awready, wready, bvalid, bresp} !== 5'b00100) $display("FAIL wdelay_commit got=%b expected=00100", {awready, wready, bvalid, bresp});
        else pass_cnt++;
        bready = 1;
        tick();
        bready = 0;
        total_cnt++;
        if (bvalid !== 1'b0) $display("FAIL wdelay_bdone bvalid=%b expected=0", bvalid);
        else pass_cnt++;
        cfg_write_delay = 0;
        cfg_read_delay = 0;
        do_read(32'h10, d, r, lat);
        total_cnt++;
        if (lat !== 0) $display("FAIL read_latency got=%0d expected=0", lat);
        else pass_cnt++;
        total_cnt++;
        if ({r, d} !== {2'b00, 32'hDEADBEEF}) $display("FAIL read_10 got=%h expected=%h", {r, d}, {2'b00, 32'hDEADBEEF});
        else pass_cnt++;
    endtask

    task automatic test_cfg_change();
        cfg_read_delay = 2;
        araddr = 32'h10; arvalid = 1;
        tick();
        cfg_read_delay = 0;
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (arready !== 1'b0) $display("FAIL cfgchg_early%0d arready=%b expected=0", i, arready);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (arready !== 1'b1) $display("FAIL cfgchg_ready arready=%b expected=1", arready);
        else pass_cnt++;
        tick();
        arvalid = 0;
        total_cnt++;
        if ({rvalid, rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL cfgchg_data got=%h expected=%h", {rvalid, rdata}, {1'b1, 32'hDEADBEEF});
        else pass_cnt++;
        rready = 1;
        tick();
        rready = 0;
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r1, r2, r;
        int          lat;
        do_write(32'h20, 32'hAABBCCDD, 4'hF, r1);
        do_write(32'h20, 32'h11223344, 4'h5, r2);
        total_cnt++;
        if ({r1, r2} !== 4'b0000) $display("FAIL strobe_bresp got=%b expected=0000", {r1, r2});
        else pass_cnt++;
        do_read(32'h20, d, r, lat);
        total_cnt++;
        if ({r, d} !== {2'b00, 32'hAA22CC44}) $display("FAIL strobe_read got=%h expected=%h", {r, d}, {2'b00, 32'hAA22CC44});
        else pass_cnt++;
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        wdata = 32'hCAFE0040; wstrb = 4'hF; wvalid = 1;
        tick();
        tick();
        wvalid = 0;
        repeat (3) tick();
        total_cnt++;
        if ({wready, bvalid} !== 2'b00) $display("FAIL wfirst_held got=%b expected=00", {wready, bvalid});
        else pass_cnt++;
        awaddr = 32'h40; awvalid = 1;
        tick();
        tick();
        awvalid = 0;
        total_cnt++;
        if ({bvalid, bresp} !== 3'b100) $display("FAIL wfirst_b1 got=%b expected=100", {bvalid, bresp});
        else pass_cnt++;
        awaddr = 32'h400; wdata = 32'h55; awvalid = 1; wvalid = 1;
        tick();
        total_cnt++;
        if ({awready, wready} !== 2'b11) $display("FAIL second_ready got=%b expected=11", {awready, wready});
        else pass_cnt++;
        tick();
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000)
                $display("FAIL bstall%0d got=%b expected=10000", i, {bvalid, bresp, awready, wready});
            else pass_cnt++;
            tick();
        end
        bready = 1;
        tick();
        bready = 0;
        total_cnt++;
        if (bvalid !== 1'b0) $display("FAIL b1_done bvalid=%b expected=0", bvalid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bvalid, bresp} !== 3'b111) $display("FAIL wfirst_b2 got=%b expected=111", {bvalid, bresp});
        else pass_cnt++;
        bready = 1;
        tick();
        bready = 0;
        repeat (3) tick();
        total_cnt++;
        if (bvalid !== 1'b0) $display("FAIL extra_b bvalid=%b expected=0", bvalid);
        else pass_cnt++;
        do_read(32'h40, d, r, lat);
        total_cnt++;
        if ({r, d} !== {2'b00, 32'hCAFE0040}) $display("FAIL wfirst_read got=%h expected=%h", {r, d}, {2'b00, 32'hCAFE0040});
        else pass_cnt++;
    endtask

    task automatic test_decerr();
        logic [31:0] d;
        logic [1:0]  r1, r2, r;
        int          lat;
        do_write(32'h0, 32'h12345678, 4'hF, r1);
        do_write(32'h400, 32'hFFFFFFFF, 4'hF, r2);
        total_cnt++;
        if ({r1, r2} !== 4'b0011) $display("FAIL decerr_bresp got=%b expected=0011", {r1, r2});
        else pass_cnt++;
        do_read(32'h400, d, r, lat);
        total_cnt++;
        if ({r, d} !== {2'b11, 32'h0}) $display("FAIL decerr_read got=%h expected=%h", {r, d}, {2'b11, 32'h0});
        else pass_cnt++;
        do_read(32'h0, d, r, lat);
        total_cnt++;
        if ({r, d} !== {2'b00, 32'h12345678}) $display("FAIL word0_kept got=%h expected=%h", {r, d}, {2'b00, 32'h12345678});
        else pass_cnt++;
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        do_write(32'h30, 32'h1, 4'hF, r);
        awaddr = 32'h30; wdata = 32'h2; wstrb = 4'hF; araddr = 32'h30;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        total_cnt++;
        if ({awready, wready, arready} !== 3'b111) $display("FAIL coll_ready got=%b expected=111", {awready, wready, arready});
        else pass_cnt++;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        total_cnt++;
        if ({rvalid, rdata, bvalid} !== {1'b1, 32'h1, 1'b1}) $display("FAIL coll_old got=%h expected=%h", {rvalid, rdata, bvalid}, {1'b1, 32'h1, 1'b1});
        else pass_cnt++;
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        do_read(32'h30, d, r, lat);
        total_cnt++;
        if ({r, d} !== {2'b00, 32'h2}) $display("FAIL coll_new got=%h expected=%h", {r, d}, {2'b00, 32'h2});
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        araddr = 32'h20; arvalid = 1;
        awaddr = 32'h20; awvalid = 1;
        tick();
        tick();
        arvalid = 0; awvalid = 0;
        total_cnt++;
        if (rvalid !== 1'b1) $display("FAIL arst_pre rvalid=%b expected=1", rvalid);
        else pass_cnt++;
        #3 aresetn = 0;
        #1;
        total_cnt++;
        if ({rvalid, arready, bvalid} !== 3'b000) $display("FAIL arst_async got=%b expected=000", {rvalid, arready, bvalid});
        else pass_cnt++;
        @(negedge aclk);
        aresetn = 1;
        tick();
        wdata = 32'h99; wstrb = 4'hF; wvalid = 1;
        tick();
        tick();
        wvalid = 0;
        repeat (2) tick();
        total_cnt++;
        if (bvalid !== 1'b0) $display("FAIL arst_abandon bvalid=%b expected=0", bvalid);
        else pass_cnt++;
        do_read(32'h20, d, r, lat);
        total_cnt++;
        if ({r, d} !== {2'b00, 32'hAA22CC44}) $display("FAIL arst_mem got=%h expected=%h", {r, d}, {2'b00, 32'hAA22CC44});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_delay();
        test_cfg_change();
        test_strobe();
        test_w_before_aw();
        test_decerr();
        test_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_mem_responder.md
Name: axi4_lite_slave_mem_responder

Overview:
Synthesisable AXI4-Lite slave endpoint backed by a word-addressed memory. Each request channel has a runtime-configurable ready-delay, and the block generates OKAY/DECERR responses. It is the parametrised successor to the fixed slave model: address width, data width, memory depth, base address and per-channel back-pressure are all configurable. It sits behind the interconnect as the target for the AVIP slave agent, or as a standalone memory in DUT-less benches.

Parameters:
- ADDRESS_WIDTH, 32, width of awaddr/araddr.
- DATA_WIDTH, 32, data width; must be 32 or 64; STRB_WIDTH = DATA_WIDTH/8.
- MEM_DEPTH, 256, number of DATA_WIDTH words; power of two.
- BASE_ADDR, 0, byte address of word 0; must be aligned to MEM_DEPTH*STRB_WIDTH.
- DELAY_WIDTH, 4, width of the ready-delay configuration inputs.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- awaddr  in  ADDRESS_WIDTH  write address
- awprot  in  3  write protection; captured, not checked
- awvalid / awready  in / out  1  write-address handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  STRB_WIDTH  byte strobes
- wvalid / wready  in / out  1  write-data handshake
- bresp  out  2  write response
- bvalid / bready  out / in  1  write-response handshake
- araddr  in  ADDRESS_WIDTH  read address
- arprot  in  3  read protection; captured, not checked
- arvalid / arready  in / out  1  read-address handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid / rready  out / in  1  read-data handshake
- cfg_write_delay  in  DELAY_WIDTH  ready delay applied to AW and W
- cfg_read_delay  in  DELAY_WIDTH  ready delay applied to AR

Behaviour:
- Reset: asynchronous, asserted while aresetn=0.
  - Clears awready, wready, bvalid, arready and rvalid to 0; clears bresp, rresp and rdata to 0.
  - Returns all FSMs to IDLE and clears the holding flags.
  - Does not clear memory contents.
  - Reset mid-transaction abandons the transaction: any pending write is not committed and no response is issued.
- Ready-delay (per channel: AW, W, AR):
  - In IDLE, the first edge k at which valid=1 loads the counter with d = cfg delay sampled at that edge. The state goes to DELAY, or to READY if d=0.
  - DELAY decrements each edge and enters READY when the count reaches 0.
  - In READY, ready=1 for exactly one cycle. The handshake completes at edge k+1+d, so minimum latency is 1 cycle; ready is always registered and never combinational from valid.
  - Changing cfg during DELAY has no effect on the current transfer.
- Write path:
  - AW and W are accepted independently, in any order, each into its own holding register with a held flag.
  - A channel whose flag is set keeps ready=0 until the write commits.
  - Commit edge: both flags set and bvalid=0. At this edge:
    - memory is updated per wstrb (byte lanes with strobe 0 are unchanged);
    - bvalid is set to 1;
    - bresp is set;
    - both flags are cleared.
  - bvalid and bresp stay stable until bready=1. One write is outstanding at most; new AW/W may be accepted while B is pending, but commit waits for the B handshake.
- Address decode:
  - index = (addr - BASE_ADDR) >> log2(STRB_WIDTH). The low log2(STRB_WIDTH) address bits are ignored, so unaligned addresses truncate.
  - addr < BASE_ADDR or index >= MEM_DEPTH gives DECERR (2'b11); such writes do not modify memory and such reads return rdata=0.
  - All other accesses give OKAY (2'b00). SLVERR and EXOKAY are never generated.
- Read path:
  - FSM states: R_IDLE -> R_DELAY -> R_ADDR (arready=1) -> R_RESP.
  - On the AR handshake edge, rdata and rresp are registered from memory and rvalid=1.
  - rvalid, rdata and rresp are held stable until rready=1; the FSM then returns to R_IDLE. One read is outstanding at most.
- Read/write collision: if an AR handshake and a write commit hit the same word on the same edge, the read returns the pre-write data.
- Read and write paths are fully independent and may complete on the same edge.

Decomposition:
- Shared package, extending the existing AXI4-Lite globals package:
  - brespEnum and rrespEnum for bresp/rresp encodings;
  - DELAY_WIDTH default;
  - new delayStateEnum {IDLE, DELAY, READY};
  - new readStateEnum {R_IDLE, R_DELAY, R_ADDR, R_RESP}.
- One sub-module: axi4_lite_ready_delay_counter, holding the per-channel counter and FSM. Its interface is valid in, cfg delay in, hold in, ready out. It is instantiated three times, for AW, W and AR.

Test Plan:
1. Reset then idle, cfg delays 0: all ready/valid outputs stay 0 for 10 cycles. Assert aresetn=0 during a read in R_RESP: rvalid=0 immediately, asynchronously.
2. cfg_write_delay=3: AW addr 0x10 and W data 0xDEADBEEF, strb 0xF, both valid at edge k.
   - awready and wready high during cycle k+3 to k+4; commit at edge k+4; bvalid=1 with bresp=OKAY.
   - Then read 0x10 with cfg_read_delay=0: arready after 1 cycle; rdata=0xDEADBEEF, rresp=OKAY.
3. Write 0xAABBCCDD to 0x20 with strb 0xF, then write 0x11223344 with strb 0x5. Read 0x20 returns 0xAA22CC44.
4. W presented 5 cycles before AW, with bready held 0 for 4 cycles after bvalid. A second AW/W is accepted but not committed until the B handshake; exactly two B responses are produced, in order.
5. Write and read at address BASE_ADDR + MEM_DEPTH*STRB_WIDTH: bresp=DECERR, rresp=DECERR, rdata=0. Memory word 0 is unchanged.
6. Same-edge AR handshake and write commit to 0x30 (old value 0x1, new value 0x2): rdata=0x1; a following read returns 0x2.
